cic_decim_ctrl: RTL
===================

Name: cic_decim_ctrl

Overview:
Sequencing controller for the CIC decimation filter datapath (integrator chain + decimator + comb chain).
- Accepts an input sample stream with valid/ready and generates the integrator and comb enables.
- Applies a runtime-selectable power-of-2 decimation rate and discards the comb-pipeline warm-up outputs.
- Presents decimated results on a valid/ready output register.

Parameters:
OUT_W, 16, width of datapath result dp_out and out_data
STAGES, 3, number of CIC stages (≥1); equals the count of decimated outputs discarded during warm-up
MAX_RATE_LOG2, 4, largest supported log2(rate); the legal rate_log2 range is 1..MAX_RATE_LOG2
RL_W, $clog2(MAX_RATE_LOG2+1), width of rate_log2

Ports:
clk  input  1  clock
rstn  input  1  asynchronous, active-low reset
enable  input  1  run request; 0 forces IDLE
rate_log2  input  RL_W  log2 of decimation rate, sampled on IDLE→WARMUP only
in_valid  input  1  input sample valid
in_ready  output  1  controller/datapath can accept a sample
integ_en  output  1  integrator chain advance (one per accepted sample)
comb_en  output  1  comb chain advance (decimation point)
dp_clr  output  1  synchronous clear of all datapath state
dp_out  input  OUT_W  comb chain result, valid the cycle after comb_en
out_data  output  OUT_W  registered decimated sample
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
phase  output  MAX_RATE_LOG2  current position within the decimation period
busy  output  1  state != IDLE
cfg_err  output  1  sticky illegal-rate flag

Behaviour:
- Reset (async, rstn=0) forces:
  - state=IDLE, phase=0, warm_cnt=0, cap_pend=0, rate latch=1.
  - outputs: out_valid=0, out_data=0, cfg_err=0, busy=0, in_ready=0, integ_en=0, comb_en=0, dp_clr=1.
- States: IDLE, WARMUP, RUN. R = 2^rate_lat.
- IDLE:
  - dp_clr=1; in_ready, integ_en and comb_en are 0.
  - enable=1 with rate_log2 in 1..MAX_RATE_LOG2: latch rate_lat=rate_log2, clear cfg_err, go to WARMUP next cycle.
  - enable=1 with an illegal rate (0 or >MAX_RATE_LOG2): cfg_err=1, stay in IDLE. cfg_err clears only when enable=0 or on a legal start.
- accept = in_valid & in_ready.
- integ_en = accept (combinational, same cycle).
- phase: increments on accept and wraps from R-1 to 0.
- comb_en = accept & (phase==R-1), same cycle as the R-th accepted sample.
- cap_pend is set the cycle after comb_en (1-cycle dp latency). On that cycle:
  - WARMUP: the result is discarded; warm_cnt increments. When warm_cnt reaches STAGES, go to RUN; the (STAGES+1)-th decimation is the first one captured.
  - RUN: out_data <= dp_out, out_valid <= 1.
- Output register:
  - out_valid clears on out_valid & out_ready, unless a new capture occurs in the same cycle, in which case it stays 1 with the new data.
  - out_data is stable while out_valid & !out_ready.
- Backpressure: in_ready = busy & !(phase==R-1 & (out_valid | cap_pend)).
  - The decimating sample is never accepted while the output slot is occupied or a capture is pending, so no output is ever dropped.
  - Conservative rule: a same-cycle out_ready does not unstall.
- enable=0 in WARMUP/RUN aborts at the next edge:
  - go to IDLE; phase=0, warm_cnt=0, cap_pend=0, out_valid=0.
  - An un-consumed output is discarded.
- rate_log2 changes while busy are ignored until the next IDLE start.
- in_valid=0 holds phase; there is no timeout.
- Rate and phase remain correct across arbitrarily long stalls.

Test Plan:
1. Reset, STAGES=3, rate_log2=2, enable=1, in_valid=1 continuously, out_ready=1.
   -> comb_en on accepted samples 4, 8, 12, …; first three decimations discarded.
   -> first out_valid one cycle after the 4th comb_en (16th sample); then one output every 4 accepts.
2. Backpressure: after the first output, hold out_ready=0 for 20 cycles.
   -> in_ready drops at phase=3; out_data stays constant.
   -> out_ready=1 restores in_ready the following cycle; no output lost or duplicated.
3. rate_log2=0, then rate_log2=MAX_RATE_LOG2+1, each with enable=1.
   -> cfg_err=1, busy=0, dp_clr=1.
   -> Then rate_log2=1: cfg_err=0, WARMUP entered, comb_en every 2nd accept.
4. Mid-run (phase=2, out_valid=1), enable=0.
   -> Next cycle: IDLE, out_valid=0, phase=0, dp_clr=1.
   -> Restart with rate_log2=3: full STAGES warm-up repeated, comb_en every 8th accept.
5. Assert rstn=0 asynchronously mid-RUN between clock edges.
   -> All outputs take their reset values immediately.
   -> After release, no output until enable=1 and warm-up completes.
6. Bursty in_valid (random 50%), rate_log2=MAX_RATE_LOG2.
   -> integ_en count == accept count.
   -> comb_en exactly every 16 accepts; captured outputs match a reference CIC model.

Source files
------------

// File: rtl/cic_decim_ctrl_if.sv
// cic_decim_ctrl_if: sample-in / result-out valid-ready handshake bundle for the CIC controller
interface cic_decim_ctrl_if #(
    parameter int OUT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: sequences integrator/comb enables of a CIC decimator, drops comb warm-up and buffers results
module cic_decim_ctrl #(
    parameter int OUT_W         = 16,
    parameter int STAGES        = 3,
    parameter int MAX_RATE_LOG2 = 4,
    parameter int RL_W          = $clog2(MAX_RATE_LOG2 + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_enable,
    input  logic [RL_W-1:0]          i_rate_log2,
    output logic                     o_integ_en,
    output logic                     o_comb_en,
    output logic                     o_dp_clr,
    input  logic [OUT_W-1:0]         i_dp_out,
    output logic [MAX_RATE_LOG2-1:0] o_phase,
    output logic                     o_busy,
    output logic                     o_cfg_err,
    cic_decim_ctrl_if.slave          io
);
    localparam int WC_W = $clog2(STAGES + 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    state_t                   r_state;
    logic [RL_W-1:0]          r_rate;
    logic [MAX_RATE_LOG2-1:0] r_phase;
    logic [WC_W-1:0]          r_warm;
    logic                     r_cap_pend;
    logic                     r_out_valid;
    logic                     r_cfg_err;
    logic [OUT_W-1:0]         r_out_data;

    logic [MAX_RATE_LOG2:0]   w_period;
    logic                     w_last;
    logic                     w_legal;
    logic                     w_busy;
    logic                     w_ready;
    logic                     w_accept;
    logic                     w_capture;

    assign w_period  = (MAX_RATE_LOG2 + 1)'(1) << r_rate;
    assign w_last    = r_phase == MAX_RATE_LOG2'(w_period - 1'b1);
    assign w_legal   = (i_rate_log2 != '0) && (i_rate_log2 <= RL_W'(MAX_RATE_LOG2));
    assign w_busy    = r_state != IDLE;
    // the decimating sample waits until the output slot and the capture pipe are both empty
    assign w_ready   = w_busy & ~(w_last & (r_out_valid | r_cap_pend));
    assign w_accept  = io.in_valid & w_ready;
    assign w_capture = r_cap_pend & (r_state == RUN);

    assign io.in_ready  = w_ready;
    assign io.out_valid = r_out_valid;
    assign io.out_data  = r_out_data;
    assign o_integ_en   = w_accept;
    assign o_comb_en    = w_accept & w_last;
    assign o_dp_clr     = ~w_busy;
    assign o_busy       = w_busy;
    assign o_phase      = r_phase;
    assign o_cfg_err    = r_cfg_err;

    // control FSM: start/abort, phase counting, warm-up discard and output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_rate      <= RL_W'(1);
            r_phase     <= '0;
            r_warm      <= '0;
            r_cap_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_out_data  <= '0;
        end else if (r_state == IDLE) begin
            r_cfg_err <= i_enable & ~w_legal;
            if (i_enable & w_legal) begin
                r_rate  <= i_rate_log2;
                r_state <= WARMUP;
            end
        end else if (!i_enable) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_warm      <= '0;
            r_cap_pend  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept)
                r_phase <= w_last ? '0 : r_phase + 1'b1;
            r_cap_pend <= w_accept & w_last;
            if (r_cap_pend && r_state == WARMUP) begin
                r_warm <= r_warm + 1'b1;
                if (r_warm == WC_W'(STAGES - 1))
                    r_state <= RUN;
            end
            if (w_capture) begin
                r_out_data  <= i_dp_out;
                r_out_valid <= 1'b1;
            end else if (r_out_valid & io.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
